// File: rtl/sram_dp_be.sv
// rtl/sram_dp_be.sv - simple-dual-port SRAM with byte enables, configurable read latency and reset-time clear sweep
module sram_dp_be #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int RD_LAT       = 1,
  parameter int WR_MODE      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_W-1:0]     wr_addrs,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     din,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     rd_addrs,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  ready
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_en;
  logic                rd_en;
  logic                collide;
  logic [DATA_W-1:0]   rd_word;
  logic                v0, v1;
  logic [DATA_W-1:0]   d0, d1;

  assign wr_en   = wr & ready & ~rst;
  assign rd_en   = rd & ready & ~rst;
  assign collide = wr_en && (wr_addrs == rd_addrs) && (WR_MODE == 1);

  // Write-first collisions forward the enabled bytes of din over the stored word
  always_comb begin
    rd_word = mem[rd_addrs];
    for (int i = 0; i < NB; i++) begin
      if (collide && be[i]) rd_word[8*i +: 8] = din[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= (state == ST_RUN);
      if (state == ST_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (&clr_ptr) state <= ST_RUN;
      end
    end
  end

  // The array itself has no reset so contents survive rst when the sweep is disabled
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[wr_addrs][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0         <= 1'b0;
      v1         <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      v0 <= rd_en;
      if (rd_en) d0 <= rd_word;
      v1 <= v0;
      if (v0) d1 <= d0;
      if (RD_LAT == 1) begin
        dout_valid <= v0;
        if (v0) dout <= d0;
      end else begin
        dout_valid <= v1;
        if (v1) dout <= d1;
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// tb/tb_sram_dp_be.sv - directed self-checking bench for sram_dp_be
module tb_sram_dp_be;

  logic        clk = 1'b0;
  logic        rst, wr, rd;
  logic [3:0]  wr_addrs, rd_addrs, be;
  logic [31:0] din;
  logic [31:0] dout1, dout2, dout3;
  logic        dv1, dv2, dv3, rdy1, rdy2, rdy3;
  int          checks = 0;
  int          failures = 0;
  int          n;
  logic [31:0] r1, r2, r3;

  always #5 clk = ~clk;

  // dut1: latency 1 read-first; dut2: latency 2 write-first; dut3: no clear sweep
  sram_dp_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RST(1)) dut1 (
    .clk(clk), .rst(rst), .wr(wr), .wr_addrs(wr_addrs), .be(be), .din(din),
    .rd(rd), .rd_addrs(rd_addrs), .dout(dout1), .dout_valid(dv1), .ready(rdy1));
  sram_dp_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .WR_MODE(1), .CLEAR_ON_RST(1)) dut2 (
    .clk(clk), .rst(rst), .wr(wr), .wr_addrs(wr_addrs), .be(be), .din(din),
    .rd(rd), .rd_addrs(rd_addrs), .dout(dout2), .dout_valid(dv2), .ready(rdy2));
  sram_dp_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RST(0)) dut3 (
    .clk(clk), .rst(rst), .wr(wr), .wr_addrs(wr_addrs), .be(be), .din(din),
    .rd(rd), .rd_addrs(rd_addrs), .dout(dout3), .dout_valid(dv3), .ready(rdy3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    wr = 1'b1; wr_addrs = a; din = d; be = b;
    step();
    wr = 1'b0; be = 4'h0;
  endtask

  task automatic read_word(input logic [3:0] a, input bit with_wr, input logic [31:0] wd,
                           output logic [31:0] o1, output logic [31:0] o2, output logic [31:0] o3);
    bit g1, g2, g3;
    g1 = 0; g2 = 0; g3 = 0;
    o1 = 'x; o2 = 'x; o3 = 'x;
    rd = 1'b1; rd_addrs = a;
    if (with_wr) begin
      wr = 1'b1; wr_addrs = a; din = wd; be = 4'hF;
    end
    step();
    rd = 1'b0; wr = 1'b0; be = 4'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (dv1 && !g1) begin g1 = 1; o1 = dout1; end
      if (dv2 && !g2) begin g2 = 1; o2 = dout2; end
      if (dv3 && !g3) begin g3 = 1; o3 = dout3; end
    end
  endtask

  task automatic count_clear(output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (rdy1) break;
      chk("busy_no_valid1", dv1, 0);
      chk("busy_no_valid2", dv2, 0);
      cnt++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wr_addrs = '0; rd_addrs = '0; be = '0; din = '0;
    step(); step();
    chk("rst_dout1", dout1, 0);
    chk("rst_valid1", dv1, 0);
    chk("rst_ready1", rdy1, 0);
    chk("rst_dout2", dout2, 0);
    chk("rst_ready2", rdy2, 0);
    chk("rst_ready3", rdy3, 0);

    // Clear sweep with reads every cycle and a write that must be ignored
    rst = 1'b0; rd = 1'b1; rd_addrs = 4'd2;
    wr = 1'b1; wr_addrs = 4'd2; din = 32'hDEADBEEF; be = 4'hF;
    step();
    chk("noclear_ready3", rdy3, 1);
    count_clear(n);
    rd = 1'b0; wr = 1'b0; be = 4'h0;
    chk("clear_len", n, 16);
    chk("ready2_after_clear", rdy2, 1);

    for (int a = 0; a < 16; a++) begin
      read_word(4'(a), 0, 32'h0, r1, r2, r3);
      chk($sformatf("cleared1_a%0d", a), r1, 0);
      chk($sformatf("cleared2_a%0d", a), r2, 0);
    end

    // Byte-enable merge
    write_word(4'd3, 32'hAABBCCDD, 4'hF);
    write_word(4'd3, 32'h11223344, 4'b0101);
    read_word(4'd3, 0, 32'h0, r1, r2, r3);
    chk("be_merge1", r1, 32'hAA22CC44);
    chk("be_merge2", r2, 32'hAA22CC44);
    chk("be_merge3", r3, 32'hAA22CC44);
    write_word(4'd4, 32'h55667788, 4'h0);
    read_word(4'd4, 0, 32'h0, r1, r2, r3);
    chk("be_zero_noop1", r1, 0);
    chk("be_zero_noop2", r2, 0);

    // Back-to-back reads: latency and consecutive valids
    write_word(4'd5, 32'h5, 4'hF);
    write_word(4'd6, 32'h6, 4'hF);
    rd = 1'b1; rd_addrs = 4'd5;
    step();
    chk("lat_e0_v1", dv1, 0);
    chk("lat_e0_v2", dv2, 0);
    rd_addrs = 4'd6;
    step();
    rd = 1'b0;
    chk("lat_e1_v1", dv1, 1);
    chk("lat_e1_d1", dout1, 32'h5);
    chk("lat_e1_v2", dv2, 0);
    step();
    chk("lat_e2_v1", dv1, 1);
    chk("lat_e2_d1", dout1, 32'h6);
    chk("lat_e2_v2", dv2, 1);
    chk("lat_e2_d2", dout2, 32'h5);
    step();
    chk("lat_e3_v1", dv1, 0);
    chk("lat_e3_hold1", dout1, 32'h6);
    chk("lat_e3_v2", dv2, 1);
    chk("lat_e3_d2", dout2, 32'h6);
    step();
    chk("lat_e4_v2", dv2, 0);
    chk("lat_e4_hold2", dout2, 32'h6);

    // Same-address collision
    write_word(4'd7, 32'h000000FF, 4'hF);
    read_word(4'd7, 1, 32'h12345678, r1, r2, r3);
    chk("coll_readfirst1", r1, 32'h000000FF);
    chk("coll_writefirst2", r2, 32'h12345678);
    chk("coll_readfirst3", r3, 32'h000000FF);
    read_word(4'd7, 0, 32'h0, r1, r2, r3);
    chk("coll_after1", r1, 32'h12345678);
    chk("coll_after2", r2, 32'h12345678);

    // Reset with a read in flight
    rd = 1'b1; rd_addrs = 4'd3;
    step();
    rd = 1'b0; rst = 1'b1;
    step();
    chk("flight_valid1", dv1, 0);
    chk("flight_dout1", dout1, 0);
    chk("flight_valid2", dv2, 0);
    chk("flight_dout2", dout2, 0);
    chk("flight_dout3", dout3, 0);
    chk("flight_ready3", rdy3, 0);

    // Reset mid-sweep at pointer 9 restarts the full clear
    rst = 1'b0;
    step();
    chk("rerun_ready3", rdy3, 1);
    repeat (8) step();
    chk("mid_clear_ready1", rdy1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    count_clear(n);
    chk("restart_len", n, 16);
    chk("post_restart_v1", dv1, 0);

    read_word(4'd3, 0, 32'h0, r1, r2, r3);
    chk("recleared1_a3", r1, 0);
    chk("recleared2_a3", r2, 0);
    chk("persist3_a3", r3, 32'hAA22CC44);
    read_word(4'd7, 0, 32'h0, r1, r2, r3);
    chk("recleared1_a7", r1, 0);
    chk("recleared2_a7", r2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
